// File: rtl/sync_filter_nff.sv
// Multi-bit synchronizer with per-bit glitch filter and edge-pulse outputs.
// Each bit is synchronized independently, so there is no coherency between bits.
module sync_filter_nff #(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int unsigned      FILTER_CYCLES = 0
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_pulse
);

    // The first stage is kept separate so that the async-capture attribute lands only on it.
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q [STAGES-1];
    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] h_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            for (int i = 0; i < int'(STAGES) - 1; i++) begin
                sync_q[i] <= RESET_VAL;
            end
        end else begin
            meta_q    <= data_in;
            sync_q[0] <= meta_q;
            for (int i = 1; i < int'(STAGES) - 1; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_last = sync_q[STAGES-2];

    if (FILTER_CYCLES == 0) begin : g_bypass
        assign data_out = s_last;
    end else begin : g_filter
        localparam int unsigned    CNT_W    = ($clog2(FILTER_CYCLES + 1) < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILTER_CYCLES - 1);

        logic [WIDTH-1:0] f_q, f_d;
        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];

        // The counter saturates at the terminal count by committing the new value, so it never wraps.
        always_comb begin
            f_d = f_q;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_d[i] = cnt_q[i];
                if (s_last[i] == f_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_TERM) begin
                    f_d[i]   = s_last[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_out) begin
            if (rst) begin
                f_q <= RESET_VAL;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                f_q   <= f_d;
                cnt_q <= cnt_d;
            end
        end

        assign data_out = f_q;
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            h_q <= RESET_VAL;
        end else begin
            h_q <= data_out;
        end
    end

    assign rise_pulse   = data_out & ~h_q;
    assign fall_pulse   = ~data_out & h_q;
    assign change_pulse = |(rise_pulse | fall_pulse);

endmodule

// File: doc/sync_filter_nff.md
# sync_filter_nff

Parametrised multi-bit synchronizer with configurable chain depth, reset value, per-bit glitch filter and edge-pulse outputs. It brings quasi-static asynchronous control/status bits (lane status, PLL lock, external enables) into the `clk_out` domain of the DSI controller. It replaces hand-written 2-flop chains plus ad-hoc edge detectors. Each bit is synchronized independently; no inter-bit coherency is provided, so multi-bit counters/buses must not pass through it.

## Interface
- `WIDTH`, 1, number of independent bits (1..32)
- `STAGES`, 2, synchronizer flops per bit (2..4)
- `RESET_VAL`, 0, `WIDTH`-bit reset value of every synchronizer, filter and history register
- `FILTER_CYCLES`, 0, consecutive stable cycles required before `data_out` follows (0 = bypass, 1..255)
- `clk_out`  in  1  destination clock
- `rst`  in  1  reset; synchronous, active-high
- `data_in`  in  WIDTH  asynchronous input bits
- `data_out`  out  WIDTH  synchronized, filtered bits
- `rise_pulse`  out  WIDTH  one-cycle pulse per bit on `data_out` 0->1
- `fall_pulse`  out  WIDTH  one-cycle pulse per bit on `data_out` 1->0
- `change_pulse`  out  1  OR-reduction of `rise_pulse | fall_pulse`

## Operation
- Sync chain: per bit, `STAGES` flops in series. Stage 1 samples `data_in`; `s_last` is the final stage output. No logic between stages.
- Bypass (`FILTER_CYCLES`=0): `data_out` = `s_last` directly, with no extra register.
- Filter (`FILTER_CYCLES`>=1): per bit, a register `f` drives `data_out`, plus a counter `cnt` of width clog2(`FILTER_CYCLES`+1), minimum 1.
  - `s_last == f`: `cnt` <= 0.
  - `s_last != f` and `cnt == FILTER_CYCLES-1`: `f` <= `s_last`, `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1.
  - Any return of `s_last` to `f` before terminal count clears `cnt`. Glitches shorter than `FILTER_CYCLES` cycles at `s_last` never reach `data_out`.
  - `cnt` never exceeds `FILTER_CYCLES-1` and does not wrap.
- Edge detect: history register `h` <= `data_out` every cycle.
  - `rise_pulse` = `data_out & ~h`.
  - `fall_pulse` = `~data_out & h`.
  - Both are combinational from registers, so they are glitch-free relative to `clk_out`.
- Reset (synchronous):
  - At a `clk_out` edge with `rst`=1, all sync stages, `f` and `h` load `RESET_VAL`, and all `cnt` load 0.
  - After that edge: `data_out`=`RESET_VAL`, `rise_pulse`=`fall_pulse`=0, `change_pulse`=0.
  - Reset mid-filter discards the partial count. Reset mid-pulse kills the pulse.
  - No pulse is generated on reset release, even if `data_in` != `RESET_VAL`; the edge appears later through normal latency.
- Simultaneous events: different bits are fully independent and may pulse in the same cycle. `change_pulse` is 1 if any bit pulses.

## Timing
- Latency from a `data_in` change (setup met before edge E0) to `data_out`: `STAGES` edges in bypass, `STAGES`+`FILTER_CYCLES` edges with filter, given the input is held stable throughout.
- A `rise_pulse`/`fall_pulse` is high exactly 1 cycle, in the first cycle the new `data_out` value is visible.
- Minimum input pulse guaranteed to propagate (filter on): `FILTER_CYCLES`+1 `clk_out` periods.
- Asynchronous sampling may add 1 cycle of uncertainty. Benches must check latency within [N, N+1] when `data_in` toggles off-edge.
- Stage-1 flops carry `ASYNC_REG` / no-retiming attributes. There is no combinational path from `data_in` to any output.

## Test plan
- Reset check, `WIDTH`=4, `RESET_VAL`=4'hA, `data_in`=4'h5, `rst` high for 3 cycles then low:
  - Response: `data_out`=4'hA and all pulses 0 while in reset.
  - Then, with `STAGES`=2 and `FILTER_CYCLES`=0, `data_out`=4'h5 two edges after release, and `rise_pulse`=4'h5 / `fall_pulse`=4'hA for exactly 1 cycle.
- Latency, `STAGES`=3, `FILTER_CYCLES`=0, `data_in`[0] 0->1 aligned to edge E0:
  - Response: `data_out`[0]=1 after E3, and `rise_pulse`[0]=1 only in the cycle following E3.
- Glitch reject, `STAGES`=2, `FILTER_CYCLES`=4:
  - Stimulus 1: a 3-cycle high pulse on `data_in`[0] -> `data_out`[0] stays 0 and no pulses.
  - Stimulus 2: a 6-cycle high pulse -> `data_out`[0] rises 6 edges after the input edge, with one `rise_pulse`.
- Independent bits, `WIDTH`=8, `FILTER_CYCLES`=2, `data_in` 8'h00->8'hF0 then 8'hF0->8'h0F four cycles apart:
  - Response: `rise_pulse`=8'hF0 in the first pulse cycle.
  - Then `rise_pulse`=8'h0F and `fall_pulse`=8'hF0 in the same later cycle.
  - `change_pulse`=1 in both cycles only.
- Reset mid-filter, `FILTER_CYCLES`=8, `data_in` high held:
  - Stimulus: assert `rst` for 1 cycle at count 5.
  - Response: `data_out` stays `RESET_VAL`=0 and no pulse occurs; after release, `data_out` rises `STAGES`+8 edges later.
- Random async toggles (hold >= `FILTER_CYCLES`+1 cycles), 10k cycles:
  - Scoreboard checks each `data_out` transition within [N, N+1] of its input edge.
  - Exactly one matching pulse per transition; no pulse without a transition.
